// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor
//
// Purpose: receives operand pairs and the product an approximate multiplier
// produced for them. It recomputes the exact product with a W-cycle
// shift-add loop, measures the error distance, and keeps running
// statistics about the errors it has seen.
//
// Optional feature: define MAX_ERR_TRACK_EN to add the max_err port and
// register. The default build omits both.
//
// Handshake: a sample transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE. Exactly one sample
// is taken per IDLE visit. Inputs are ignored in any other state.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   in_valid/ready   sample handshake
//   op_a, op_b       operands (W bits)
//   approx_p         approximate product under test (2W bits)
//   clear            synchronous zeroing of the statistics registers only
//   busy             high in MULT or CMP
//   res_valid        one-cycle pulse when a result is registered
//   exact_p          exact product of the last sample
//   err_dist         |exact_p - approx_p| of the last sample
//   err_flag         err_dist != 0 for the last sample
//   sample_cnt       samples evaluated (saturating)
//   err_cnt          samples with nonzero error (saturating)
//   sum_err          sum of err_dist (saturating)
//   max_err          largest err_dist seen (MAX_ERR_TRACK_EN only)
module approx_mult_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       op_a,
  input  logic [W-1:0]       op_b,
  input  logic [2*W-1:0]     approx_p,
  input  logic               clear,
  output logic               busy,
  output logic               res_valid,
  output logic [2*W-1:0]     exact_p,
  output logic [2*W-1:0]     err_dist,
  output logic               err_flag,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   sum_err
`ifdef MAX_ERR_TRACK_EN
  ,
  output logic [2*W-1:0]     max_err
`endif
);

  localparam int PW    = 2 * W;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  // The accumulator sum is formed one bit wider than the larger of the two
  // operands. This keeps the overflow detectable even when ACC_W < 2W.
  localparam int SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;

  logic [1:0]       state;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [PW-1:0]    approx_r;
  logic [PW-1:0]    pp;
  logic [IDX_W-1:0] idx;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    diff;
  logic [SUM_W-1:0] sum_wide;
  logic [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0] sample_next;
  logic [CNT_W-1:0] err_next;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_MULT) || (state == S_CMP);

  // Datapath for one shift-add step, plus the values used at the CMP edge.
  always_comb begin
    addend = '0;
    if (b_r[idx]) begin
      addend = PW'(a_r) << idx;
    end

    diff = (pp >= approx_r) ? (pp - approx_r) : (approx_r - pp);

    sum_wide = SUM_W'(sum_err) + SUM_W'(diff);
    sum_next = (sum_wide > SUM_W'(ACC_MAX)) ? ACC_MAX : sum_wide[ACC_W-1:0];

    sample_next = (sample_cnt == CNT_MAX) ? sample_cnt
                                          : sample_cnt + CNT_W'(1);
    err_next    = err_cnt;
    if ((diff != '0) && (err_cnt != CNT_MAX)) begin
      err_next = err_cnt + CNT_W'(1);
    end
  end

  // Control FSM and per-sample result registers. clear does not touch these.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      approx_r  <= '0;
      pp        <= '0;
      idx       <= '0;
      exact_p   <= '0;
      err_dist  <= '0;
      err_flag  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r      <= op_a;
            b_r      <= op_b;
            approx_r <= approx_p;
            pp       <= '0;
            idx      <= '0;
            state    <= S_MULT;
          end
        end
        S_MULT: begin
          pp  <= pp + addend;
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state <= S_CMP;
          end
        end
        S_CMP: begin
          exact_p   <= pp;
          err_dist  <= diff;
          err_flag  <= (diff != '0);
          res_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Statistics. When clear lands on the CMP edge it takes priority, so that
  // sample is dropped from the statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_err    <= '0;
    end else if (clear) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_err    <= '0;
    end else if (state == S_CMP) begin
      sample_cnt <= sample_next;
      err_cnt    <= err_next;
      sum_err    <= sum_next;
    end
  end

`ifdef MAX_ERR_TRACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_err <= '0;
    end else if (clear) begin
      max_err <= '0;
    end else if ((state == S_CMP) && (diff > max_err)) begin
      max_err <= diff;
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Testbench for approx_mult_err_monitor. The main instance uses the default
// parameters. A second instance with ACC_W=8 exercises accumulator
// saturation. Results are checked against a queue of expected records that
// is filled when samples are driven.
module tb_approx_mult_err_monitor;

  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = 32;
  localparam int PW    = 2 * W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance signals
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     op_a = '0;
  logic [W-1:0]     op_b = '0;
  logic [PW-1:0]    approx_p = '0;
  logic             clear = 1'b0;
  logic             busy;
  logic             res_valid;
  logic [PW-1:0]    exact_p;
  logic [PW-1:0]    err_dist;
  logic             err_flag;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [ACC_W-1:0] sum_err;
`ifdef MAX_ERR_TRACK_EN
  logic [PW-1:0]    max_err;
`endif

  // saturation instance signals (shares operands, clear and reset)
  logic             in_valid2 = 1'b0;
  logic             in_ready2;
  logic             busy2;
  logic             res_valid2;
  logic [PW-1:0]    exact_p2;
  logic [PW-1:0]    err_dist2;
  logic             err_flag2;
  logic [CNT_W-1:0] sample_cnt2;
  logic [CNT_W-1:0] err_cnt2;
  logic [7:0]       sum_err2;
`ifdef MAX_ERR_TRACK_EN
  logic [PW-1:0]    max_err2;
`endif

  approx_mult_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .approx_p(approx_p), .clear(clear),
    .busy(busy), .res_valid(res_valid), .exact_p(exact_p),
    .err_dist(err_dist), .err_flag(err_flag), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .sum_err(sum_err)
`ifdef MAX_ERR_TRACK_EN
    , .max_err(max_err)
`endif
  );

  approx_mult_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(8)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .op_a(op_a), .op_b(op_b), .approx_p(approx_p), .clear(clear),
    .busy(busy2), .res_valid(res_valid2), .exact_p(exact_p2),
    .err_dist(err_dist2), .err_flag(err_flag2), .sample_cnt(sample_cnt2),
    .err_cnt(err_cnt2), .sum_err(sum_err2)
`ifdef MAX_ERR_TRACK_EN
    , .max_err(max_err2)
`endif
  );

  // scoreboard
  typedef struct packed {
    logic [PW-1:0]    exact;
    logic [PW-1:0]    err;
    logic             flag;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] errc;
    logic [ACC_W-1:0] sum;
    logic [PW-1:0]    mx;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int errors  = 0;
  int checks  = 0;
  int rv_seen = 0;
  int pushes  = 0;

  // reference statistics
  logic [CNT_W-1:0] m_cnt  = '0;
  logic [CNT_W-1:0] m_errc = '0;
  logic [ACC_W-1:0] m_sum  = '0;
  logic [PW-1:0]    m_max  = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_errc = '0; m_sum = '0; m_max = '0;
  endtask

  // Pushes the expected record for one sample. clr models a clear pulse
  // that lands on this sample's compare edge.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [PW-1:0] p, input bit clr);
    exp_t e;
    logic [PW-1:0] ex;
    logic [32:0]   s;
    ex      = PW'(a) * PW'(b);
    e.exact = ex;
    e.err   = (ex >= p) ? ex - p : p - ex;
    e.flag  = (e.err != '0);
    if (clr) begin
      model_reset();
    end else begin
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (e.flag && m_errc != '1) m_errc = m_errc + 1'b1;
      s = 33'(m_sum) + 33'(e.err);
      m_sum = (s > 33'h0_FFFF_FFFF) ? '1 : s[31:0];
      if (e.err > m_max) m_max = e.err;
    end
    e.cnt  = m_cnt;
    e.errc = m_errc;
    e.sum  = m_sum;
    e.mx   = m_max;
    exp_q.push_back(e);
    pushes++;
  endtask

  // result monitor, sampling away from the active edge
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      rv_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected observed=res_valid expected=no result");
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_exact_p",   32'(exact_p),    32'(sb_e.exact));
        check("sb_err_dist",  32'(err_dist),   32'(sb_e.err));
        check("sb_err_flag",  32'(err_flag),   32'(sb_e.flag));
        check("sb_sample_cnt", 32'(sample_cnt), 32'(sb_e.cnt));
        check("sb_err_cnt",   32'(err_cnt),    32'(sb_e.errc));
        check("sb_sum_err",   sum_err,         sb_e.sum);
`ifdef MAX_ERR_TRACK_EN
        check("sb_max_err",   32'(max_err),    32'(sb_e.mx));
`endif
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Offers one sample; returns just after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [PW-1:0] p, input bit push);
    @(negedge clk);
    wait_ready();
    op_a = a; op_b = b; approx_p = p;
    in_valid = 1'b1;
    if (push) push_exp(a, b, p, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from accept until res_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic send_sat(input logic [PW-1:0] p, input logic [7:0] exp_sum,
                          input logic [CNT_W-1:0] exp_cnt);
    int n;
    @(negedge clk);
    op_a = '0; op_b = '0; approx_p = p;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    n = 0;
    while (!res_valid2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("sat_latency",    32'(n),           32'd9);
    check("sat_err_dist",   32'(err_dist2),   32'(p));
    check("sat_sample_cnt", 32'(sample_cnt2), 32'(exp_cnt));
    check("sat_sum_err",    32'(sum_err2),    32'(exp_sum));
  endtask

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  int lat;
  int acc_cyc[$];
  int rv0;

  initial begin
    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_res_valid",  32'(res_valid),  32'd0);
    check("rst_exact_p",    32'(exact_p),    32'd0);
    check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    check("rst_sum_err",    sum_err,         32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready",  32'(in_ready),   32'd1);

    // exact match, with latency measurement
    send(8'h0F, 8'h0F, 16'h00E1, 1'b1);
    check("mult_busy", 32'(busy), 32'd1);
    check("mult_in_ready", 32'(in_ready), 32'd0);
    wait_result(lat);
    check("latency_exact", 32'(lat), 32'd9);

    // exact above approximate
    send(8'hFF, 8'hFF, 16'hFE00, 1'b1);
    wait_result(lat);
    check("latency_above", 32'(lat), 32'd9);

    // exact below approximate
    send(8'h02, 8'h03, 16'h000A, 1'b1);
    wait_result(lat);
    check("latency_below", 32'(lat), 32'd9);

    // held in_valid with operands changing every cycle; a clear pulse is
    // placed on the compare edge of the second sample
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      op_a     = 8'($urandom_range(0, 255));
      op_b     = 8'($urandom_range(0, 255));
      approx_p = 16'($urandom_range(0, 65535));
      clear    = (acc_cyc.size() >= 2) && (i == acc_cyc[1] + 9);
      if (in_ready) begin
        push_exp(op_a, op_b, approx_p, acc_cyc.size() == 1);
        acc_cyc.push_back(i);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (12) @(negedge clk);
    check("held_accepts", 32'(acc_cyc.size()), 32'd4);
    for (int j = 1; j < acc_cyc.size(); j++) begin
      check("held_accept_gap", 32'(acc_cyc[j] - acc_cyc[j-1]), 32'd10);
    end

    // reset in the 4th MULT cycle
    send(8'h12, 8'h34, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_busy",       32'(busy),       32'd0);
    check("midrst_in_ready",   32'(in_ready),   32'd1);
    check("midrst_exact_p",    32'(exact_p),    32'd0);
    check("midrst_err_dist",   32'(err_dist),   32'd0);
    check("midrst_err_flag",   32'(err_flag),   32'd0);
    check("midrst_sample_cnt", 32'(sample_cnt), 32'd0);
    check("midrst_err_cnt",    32'(err_cnt),    32'd0);
    check("midrst_sum_err",    sum_err,         32'd0);
`ifdef MAX_ERR_TRACK_EN
    check("midrst_max_err",    32'(max_err),    32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rv0 = rv_seen;
    repeat (12) @(negedge clk);
    check("midrst_no_result", 32'(rv_seen - rv0), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(8'hA5, 8'h3C, 16'h2000, 1'b1);
    wait_result(lat);
    check("latency_post_rst", 32'(lat), 32'd9);

    // accumulator saturation on the ACC_W=8 instance
    send_sat(16'h00C8, 8'hC8, 16'd1);
    send_sat(16'h00C8, 8'hFF, 16'd2);
    send_sat(16'h00C8, 8'hFF, 16'd3);

    // final report
    repeat (3) @(negedge clk);
    check("queue_empty",  32'(exp_q.size()), 32'd0);
    check("result_count", 32'(rv_seen),      32'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/approx_mult_err_monitor.md
# approx_mult_err_monitor

Sequential consumer and checker for the approximate 8x8 Vedic multiplier's product stream. It accepts an operand pair together with the approximate product through a valid/ready handshake. It then recomputes the exact product with an iterative shift-add datapath, computes the error distance, and accumulates running error statistics. It sits beside the DCT datapath as a characterization and monitoring block, and is the receiving end of the approximate multiplier's output.

## Interface
Parameters:
- W, 8, operand width; products are 2W bits
- CNT_W, 16, width of the sample and error counters
- ACC_W, 32, width of the error-distance accumulator

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/product sample offered
- in_ready  output  1  block can accept a sample (high only in IDLE)
- op_a  input  W  multiplicand
- op_b  input  W  multiplier
- approx_p  input  2W  approximate product under test
- clear  input  1  synchronous clear of the statistics registers
- busy  output  1  high in MULT or CMP
- res_valid  output  1  one-cycle pulse when a result is registered
- exact_p  output  2W  exact product of the last sample
- err_dist  output  2W  |exact_p - approx_p| of the last sample
- err_flag  output  1  err_dist != 0 for the last sample
- sample_cnt  output  CNT_W  samples evaluated (saturating)
- err_cnt  output  CNT_W  samples with nonzero error (saturating)
- sum_err  output  ACC_W  sum of err_dist (saturating)
- max_err  output  2W  largest err_dist seen; present only with MAX_ERR_TRACK_EN

## Operation
- Reset: state IDLE. All registered outputs and internal registers are 0. in_ready = 1 because it is decoded from IDLE. busy = 0.
- IDLE: in_ready = 1. When in_valid & in_ready at an edge:
  - latch op_a, op_b and approx_p
  - clear the partial product and the bit index
  - go to MULT
- MULT: W cycles. At bit index i, if op_b[i] then add (op_a << i) to the partial product. The partial product is 2W bits unsigned and cannot overflow. After index W-1, go to CMP.
- CMP: one cycle. At this edge:
  - exact_p <= partial product
  - err_dist <= absolute difference in 2W bits, unsigned, in either direction
  - err_flag <= (difference != 0)
  - res_valid <= 1
  - sample_cnt += 1; err_cnt += err_flag; sum_err += err_dist zero-extended
  - go to IDLE
- res_valid deasserts at the next edge.
- Saturation: the counters and the accumulator hold at all-ones and never wrap.
- clear: has no effect on the FSM, exact_p, err_dist, err_flag or res_valid.
  - It zeroes sample_cnt, err_cnt, sum_err and max_err.
  - If clear coincides with the CMP edge, clear wins and that sample is not counted. Its per-sample outputs are still produced.
- Inputs outside IDLE are ignored. Latched operands are immune to input changes mid-operation.
- Reset mid-operation returns to IDLE immediately (asynchronously) and zeroes everything. The in-flight sample is lost and no res_valid is produced.

## Timing
- Accept at edge 0. MULT occupies edges 1..W. The CMP update happens at edge W+1, and res_valid is high from edge W+1 to edge W+2.
- Latency is W+1 cycles from accept to res_valid (9 for W=8).
- in_ready reasserts after edge W+1, so the earliest next accept is at edge W+2. Minimum spacing is W+2 cycles per sample.
- in_valid may stay high continuously; exactly one sample is taken per IDLE visit.
- Statistics outputs are registered and reflect a sample from the edge that raises res_valid.

## Configuration
- MAX_ERR_TRACK_EN defined:
  - the max_err port and register exist
  - at the CMP edge, max_err <= err_dist if err_dist > max_err
  - cleared by rst and by clear
- Undefined: the max_err port and register are omitted. All other behaviour is identical.

## Test plan
- **Exact match:** op_a=0x0F, op_b=0x0F, approx_p=0x00E1.
  - Expect exact_p=0x00E1, err_dist=0, err_flag=0, sample_cnt=1, err_cnt=0.
  - res_valid goes high exactly 9 cycles after accept.
- **Exact above approximate:** op_a=0xFF, op_b=0xFF, approx_p=0xFE00.
  - Expect exact_p=0xFE01, err_dist=1, err_flag=1, err_cnt=1, sum_err=1, max_err=1 (macro on).
- **Exact below approximate:** op_a=0x02, op_b=0x03, approx_p=0x000A.
  - Expect exact_p=0x0006, err_dist=4, sum_err accumulating to 5 after the previous case, max_err=4.
- **Held in_valid:** hold in_valid=1 with changing operands.
  - Accepts occur only every 10 cycles.
  - Operands changed during MULT do not alter exact_p.
  - A clear pulse coinciding with the CMP edge gives sample_cnt=0 with res_valid still pulsing.
- **Reset mid-operation:** assert rst in the 4th MULT cycle.
  - All outputs go to 0 immediately and no res_valid appears.
  - After release, in_ready=1 and a new sample completes normally.
- **Saturation:** instantiate with ACC_W=8 and send two samples of err_dist=0xC8 (op_a=0, op_b=0, approx_p=0x00C8).
  - Expect sum_err=0xC8, then 0xFF, held at 0xFF on a third sample.
